pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-rate game sequencer for the Pong datapath. It consumes the per-frame collision indications from collision detection (paddle 1, paddle 2, playfield wall) and the vertical frame tick. It owns ball position and direction, both player scores, the serve delay and the game-over condition. Its ball coordinates feed the ball renderer, whose output in turn drives collision detection on the next frame.

## Interface
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- SPEED, 2, pixels moved per axis per frame
- SERVE_FRAMES, 60, frames the ball is held at centre before a serve
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- start  in  1  one-cycle pulse, already synchronised and debounced
- hit_paddle_1  in  1  ball overlapped left paddle this cycle
- hit_paddle_2  in  1  ball overlapped right paddle this cycle
- hit_wall  in  1  ball overlapped top/bottom frame this cycle
- ball_x  out  10  ball left edge
- ball_y  out  10  ball top edge
- score_1  out  4  left player score
- score_2  out  4  right player score
- state  out  3  current FSM state, encoding from package
- game_over  out  1  high while in OVER

## Operation
- Hit inputs are OR-accumulated into sticky flags between ticks. All flags are cleared on frame_tick, and a hit arriving in the same cycle as the tick counts toward the next frame.
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE:
  - Ball at centre, scores held.
  - On start: clear scores and go to SERVE with serve direction right.
- SERVE:
  - Ball at centre (x = H_ACTIVE/2 − BALL_SIZE/2, y = V_ACTIVE/2 − BALL_SIZE/2).
  - Decrement the frame counter on each tick. On the tick where the counter reaches 0, go to PLAY; movement begins on the following tick.
- PLAY, on each frame_tick, in this order:
  1. Reflect:
     - Sticky paddle 1 sets dir_x = right, honoured only if moving left.
     - Sticky paddle 2 sets dir_x = left, honoured only if moving right.
     - Sticky wall flips dir_y only if the ball is moving toward the nearer wall (top half moving up, bottom half moving down).
     - If paddle 1 and paddle 2 are both set, only the one matching the current dir_x acts.
  2. Goal check, on post-reflection direction:
     - Moving left with ball_x < SPEED: point to player 2, go to POINT.
     - Moving right with ball_x > H_ACTIVE − BALL_SIZE − SPEED: point to player 1, go to POINT.
     - On a goal, position is not updated.
  3. Step:
     - Add or subtract SPEED on each axis.
     - y is clamped to [0, V_ACTIVE − BALL_SIZE], and dir_y flips when the clamp engages (backup for a missed wall hit).
- POINT:
  - Increment the scorer's score on the entry cycle. Scores saturate at WIN_SCORE.
  - If the new score equals WIN_SCORE, go to OVER. Otherwise load the serve counter and go to SERVE.
  - The serve goes toward the player who conceded. dir_y toggles every serve.
- OVER: ball frozen, game_over = 1. On start: clear scores and go to SERVE.
- start is ignored in SERVE, PLAY and POINT.
- Arithmetic is 10-bit unsigned. No x wrap is possible, because goals are detected before the step.

## Timing
- Reset values:
  - state = IDLE, ball at centre (316, 236 at defaults).
  - Scores 0, dir_x right, dir_y down.
  - Serve counter = SERVE_FRAMES, sticky flags 0, game_over 0.
- All outputs are registered. Position and score changes appear 1 clk after the causing frame_tick.
- POINT lasts exactly 1 clk.
- IDLE/OVER to SERVE takes 1 clk after start.
- Serve delay is exactly SERVE_FRAMES ticks from SERVE entry to PLAY entry.
- rst mid-game returns to reset values on the next clk edge regardless of state or pending flags.

## Structure
- Shared package pong_pkg holds:
  - The state enum.
  - The screen constants H_ACTIVE, V_ACTIVE and BALL_SIZE, also used by the renderer and collision logic.
  - The centre-position constants.
- Sub-module frame_counter: a loadable down-counter enabled by frame_tick, with a zero flag. It is used for the serve delay.

## Test plan
- Reset, then start, then 60 ticks: state stays SERVE for ticks 1–59 and enters PLAY on tick 60. The next tick gives ball_x = 318, ball_y = 238.
- In PLAY moving left, pulse hit_paddle_1 mid-frame, then tick: dir_x becomes right and ball_x increases by 2. A second hit_paddle_1 on a later frame, while still moving right, causes no change.
- hit_paddle_1 and hit_paddle_2 in the same frame while moving right: only paddle 2 acts, and ball_x decreases by 2.
- Ball moving left at ball_x = 1 with no hits, then tick: score_2 = 1 and the state goes through POINT to SERVE, with the ball at centre and the serve direction left.
- score_1 = 8, then a goal on the right side: score_1 = 9, state = OVER, game_over = 1. start gives scores 0 and state SERVE.
- Assert rst during PLAY while a hit_wall flag is pending: the next cycle shows the reset values, and the pending flag has no effect after release.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong constants: screen geometry, ball centre position and the
// controller state encoding used by the game sequencer and its observers.
package pong_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BALL_SIZE = 8;

    // Ball top-left corner when it sits in the middle of the playfield.
    localparam logic [9:0] BALL_X_CENTRE = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0] BALL_Y_CENTRE = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);

    // Game sequencer states, exported on the state port.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

endpackage

// File: rtl/frame_counter.sv
// Loadable down-counter advanced by the frame tick. o_zero flags the enabled
// tick that brings the count to zero, so the caller can act on that same tick.
module frame_counter
    import pong_pkg::*;
#(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load wins over counting; the count rests at zero once reached.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = i_en && !i_load && (r_count <= W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: owns ball position/direction, scores, serve delay
// and game-over. frame_tick and start are single-cycle pulses with no
// back-pressure; hits are level inputs sampled every cycle into sticky flags.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       hit_paddle_1,
    input  logic       hit_paddle_2,
    input  logic       hit_wall,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic [2:0] state,
    output logic       game_over
);

    localparam logic [9:0] SPD    = 10'(SPEED);
    localparam logic [9:0] X_GOAL = 10'(H_ACTIVE - BALL_SIZE - SPEED);
    localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [3:0] WIN4   = 4'(WIN_SCORE);

    logic [2:0] r_state;
    logic [9:0] r_ball_x, r_ball_y;
    logic [3:0] r_score_1, r_score_2;
    logic       r_dir_x;              // 1 = moving right
    logic       r_dir_y;              // 1 = moving down
    logic       r_hit_p1, r_hit_p2, r_hit_wall;
    logic       r_scorer_2;           // last point went to player 2
    logic       r_game_over;

    logic       w_dir_x_refl, w_dir_y_refl, w_dir_y_step;
    logic       w_top_half, w_goal_1, w_goal_2;
    logic [9:0] w_next_x, w_next_y;
    logic [3:0] w_score_1_inc, w_score_2_inc;
    logic       w_point_win, w_serve_load, w_cnt_zero;

    // Hits accumulate between ticks; a hit coincident with a tick belongs to the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_p1   <= 1'b0;
            r_hit_p2   <= 1'b0;
            r_hit_wall <= 1'b0;
        end else if (frame_tick) begin
            r_hit_p1   <= hit_paddle_1;
            r_hit_p2   <= hit_paddle_2;
            r_hit_wall <= hit_wall;
        end else begin
            r_hit_p1   <= r_hit_p1 | hit_paddle_1;
            r_hit_p2   <= r_hit_p2 | hit_paddle_2;
            r_hit_wall <= r_hit_wall | hit_wall;
        end
    end

    // Per-frame reflect, goal check and step, evaluated from the sticky flags.
    always_comb begin
        w_dir_x_refl = r_dir_x;
        if (!r_dir_x && r_hit_p1) begin
            w_dir_x_refl = 1'b1;
        end else if (r_dir_x && r_hit_p2) begin
            w_dir_x_refl = 1'b0;
        end

        w_top_half   = r_ball_y < BALL_Y_CENTRE;
        w_dir_y_refl = r_dir_y;
        if (r_hit_wall && (w_top_half ? !r_dir_y : r_dir_y)) begin
            w_dir_y_refl = !r_dir_y;
        end

        w_goal_2 = !w_dir_x_refl && (r_ball_x < SPD);
        w_goal_1 = w_dir_x_refl && (r_ball_x > X_GOAL);
        w_next_x = w_dir_x_refl ? (r_ball_x + SPD) : (r_ball_x - SPD);

        // Clamp also reverses direction in case a wall hit was missed.
        w_dir_y_step = w_dir_y_refl;
        if (w_dir_y_refl) begin
            if (r_ball_y > (Y_MAX - SPD)) begin
                w_next_y     = Y_MAX;
                w_dir_y_step = 1'b0;
            end else begin
                w_next_y = r_ball_y + SPD;
            end
        end else begin
            if (r_ball_y < SPD) begin
                w_next_y     = 10'd0;
                w_dir_y_step = 1'b1;
            end else begin
                w_next_y = r_ball_y - SPD;
            end
        end

        w_score_1_inc = (r_score_1 >= WIN4) ? WIN4 : (r_score_1 + 4'd1);
        w_score_2_inc = (r_score_2 >= WIN4) ? WIN4 : (r_score_2 + 4'd1);
        w_point_win   = r_scorer_2 ? (r_score_2 == WIN4) : (r_score_1 == WIN4);
        w_serve_load  = (((r_state == ST_IDLE) || (r_state == ST_OVER)) && start)
                        || ((r_state == ST_POINT) && !w_point_win);
    end

    frame_counter #(
        .W       (8),
        .RST_VAL (8'(SERVE_FRAMES))
    ) u_serve_cnt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_serve_load),
        .i_load_val (8'(SERVE_FRAMES)),
        .i_en       (frame_tick && (r_state == ST_SERVE)),
        .o_zero     (w_cnt_zero)
    );

    // Game sequencer: state, ball, direction and score registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ball_x    <= BALL_X_CENTRE;
            r_ball_y    <= BALL_Y_CENTRE;
            r_score_1   <= 4'd0;
            r_score_2   <= 4'd0;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_scorer_2  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        r_state     <= ST_SERVE;
                        r_score_1   <= 4'd0;
                        r_score_2   <= 4'd0;
                        r_ball_x    <= BALL_X_CENTRE;
                        r_ball_y    <= BALL_Y_CENTRE;
                        r_dir_x     <= 1'b1;
                        r_dir_y     <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        r_dir_x <= w_dir_x_refl;
                        if (w_goal_2) begin
                            r_dir_y    <= w_dir_y_refl;
                            r_score_2  <= w_score_2_inc;
                            r_scorer_2 <= 1'b1;
                            r_state    <= ST_POINT;
                        end else if (w_goal_1) begin
                            r_dir_y    <= w_dir_y_refl;
                            r_score_1  <= w_score_1_inc;
                            r_scorer_2 <= 1'b0;
                            r_state    <= ST_POINT;
                        end else begin
                            r_ball_x <= w_next_x;
                            r_ball_y <= w_next_y;
                            r_dir_y  <= w_dir_y_step;
                        end
                    end
                end
                ST_POINT: begin
                    if (w_point_win) begin
                        r_state     <= ST_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        // Serve toward the player who conceded.
                        r_state  <= ST_SERVE;
                        r_ball_x <= BALL_X_CENTRE;
                        r_ball_y <= BALL_Y_CENTRE;
                        r_dir_x  <= !r_scorer_2;
                        r_dir_y  <= !r_dir_y;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign score_1   = r_score_1;
    assign score_2   = r_score_2;
    assign state     = r_state;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios plus randomized play, checked
// against a frame-level behavioural model of the game rules.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    localparam int SPEED        = 2;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;
    localparam int CX           = H_ACTIVE / 2 - BALL_SIZE / 2;
    localparam int CY           = V_ACTIVE / 2 - BALL_SIZE / 2;

    logic       clk = 1'b0;
    logic       rst, frame_tick, start, hit_paddle_1, hit_paddle_2, hit_wall;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_1, score_2;
    logic [2:0] state;
    logic       game_over;
    logic [31:0] w_dut;

    int n_vec = 0;
    int n_err = 0;

    // Reference model (signed ints, +1/-1 directions)
    logic [2:0] m_state;
    int m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_go, m_cnt, m_scorer;
    bit m_f1, m_f2, m_fw;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .SPEED        (SPEED),
        .SERVE_FRAMES (SERVE_FRAMES),
        .WIN_SCORE    (WIN_SCORE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .start        (start),
        .hit_paddle_1 (hit_paddle_1),
        .hit_paddle_2 (hit_paddle_2),
        .hit_wall     (hit_wall),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .score_1      (score_1),
        .score_2      (score_2),
        .state        (state),
        .game_over    (game_over)
    );

    assign w_dut = {state, ball_x, ball_y, score_1, score_2, game_over};

    function automatic logic [31:0] model_vec();
        return {m_state, 10'(m_x), 10'(m_y), 4'(m_s1), 4'(m_s2), 1'(m_go)};
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
        m_s1 = 0; m_s2 = 0; m_go = 0; m_cnt = 0; m_scorer = 0;
        m_f1 = 0; m_f2 = 0; m_fw = 0;
    endtask

    task automatic model_new_serve(input int dx, input int dy);
        m_state = ST_SERVE; m_cnt = 0; m_x = CX; m_y = CY; m_dx = dx; m_dy = dy;
    endtask

    task automatic model_frame();
        int dx, dy;
        bit top;
        dx = m_dx; dy = m_dy;
        if (dx < 0 && m_f1) dx = 1;
        else if (dx > 0 && m_f2) dx = -1;
        top = (m_y + BALL_SIZE / 2) < (V_ACTIVE / 2);
        if (m_fw && ((top && dy < 0) || (!top && dy > 0))) dy = -dy;
        m_dx = dx; m_dy = dy;
        if (dx < 0 && m_x < SPEED) begin
            m_s2 = (m_s2 + 1 > WIN_SCORE) ? WIN_SCORE : m_s2 + 1;
            m_scorer = 2; m_state = ST_POINT;
        end else if (dx > 0 && m_x > H_ACTIVE - BALL_SIZE - SPEED) begin
            m_s1 = (m_s1 + 1 > WIN_SCORE) ? WIN_SCORE : m_s1 + 1;
            m_scorer = 1; m_state = ST_POINT;
        end else begin
            m_x = m_x + dx * SPEED;
            m_y = m_y + dy * SPEED;
            if (m_y < 0) begin
                m_y = 0; m_dy = 1;
            end else if (m_y > V_ACTIVE - BALL_SIZE) begin
                m_y = V_ACTIVE - BALL_SIZE; m_dy = -1;
            end
        end
    endtask

    task automatic model_clock(input bit r, input bit t, input bit s,
                               input bit h1, input bit h2, input bit hw);
        if (r) begin
            model_reset();
            return;
        end
        case (m_state)
            ST_IDLE, ST_OVER: if (s) begin
                m_s1 = 0; m_s2 = 0; m_go = 0;
                model_new_serve(1, 1);
            end
            ST_SERVE: if (t) begin
                m_cnt++;
                if (m_cnt == SERVE_FRAMES) m_state = ST_PLAY;
            end
            ST_PLAY: if (t) model_frame();
            ST_POINT: begin
                if ((m_scorer == 2 ? m_s2 : m_s1) == WIN_SCORE) begin
                    m_state = ST_OVER; m_go = 1;
                end else begin
                    model_new_serve(m_scorer == 2 ? -1 : 1, -m_dy);
                end
            end
            default: ;
        endcase
        if (t) begin
            m_f1 = h1; m_f2 = h2; m_fw = hw;
        end else begin
            m_f1 = m_f1 | h1; m_f2 = m_f2 | h2; m_fw = m_fw | hw;
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1 ns after the edge.
    task automatic cyc(input bit r, input bit t, input bit s,
                       input bit h1, input bit h2, input bit hw);
        rst = r; frame_tick = t; start = s;
        hit_paddle_1 = h1; hit_paddle_2 = h2; hit_wall = hw;
        @(posedge clk);
        model_clock(r, t, s, h1, h2, hw);
        #1;
        rst = 1'b0; frame_tick = 1'b0; start = 1'b0;
        hit_paddle_1 = 1'b0; hit_paddle_2 = 1'b0; hit_wall = 1'b0;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (w_dut !== {ST_IDLE, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got %h want %h", w_dut, {ST_IDLE, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 1, 1);
            n_vec++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL idle_hold[%0d]: got %h want %h", i, w_dut, model_vec());
            end
        end
    endtask

    task automatic test_serve();
        logic [2:0] exp_st;
        cyc(0, 0, 1, 0, 0, 0);
        n_vec++;
        if (state !== ST_SERVE || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL start_to_serve: got %h want %h", w_dut, model_vec());
        end
        for (int i = 1; i <= SERVE_FRAMES; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            exp_st = (i < SERVE_FRAMES) ? ST_SERVE : ST_PLAY;
            n_vec++;
            if (state !== exp_st || w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL serve_tick%0d: got state %0d want %0d", i, state, exp_st);
            end
        end
        cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
            n_err++;
            $display("FAIL first_step: got x=%0d y=%0d want x=318 y=238", ball_x, ball_y);
        end
    endtask

    task automatic test_paddle();
        int x0;
        cyc(0, 1, 0, 0, 0, 0);
        // both paddles while moving right: only paddle 2 acts
        cyc(0, 0, 0, 1, 1, 0);
        x0 = m_x;
        cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_x !== 10'(x0 - SPEED) || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL both_paddles: got x=%0d want %0d", ball_x, x0 - SPEED);
        end
        // paddle 1 while moving left reflects right
        x0 = m_x;
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_x !== 10'(x0 + SPEED) || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL paddle1_reflect: got x=%0d want %0d", ball_x, x0 + SPEED);
        end
        // paddle 1 again while already moving right: no change
        x0 = m_x;
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_x !== 10'(x0 + SPEED) || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL paddle1_ignored: got x=%0d want %0d", ball_x, x0 + SPEED);
        end
        // paddle 2 coincident with the tick counts for the next frame
        x0 = m_x;
        cyc(0, 1, 0, 0, 1, 0);
        n_vec++;
        if (ball_x !== 10'(x0 + SPEED)) begin
            n_err++;
            $display("FAIL hit_on_tick_deferred: got x=%0d want %0d", ball_x, x0 + SPEED);
        end
        x0 = m_x;
        cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_x !== 10'(x0 - SPEED) || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL hit_on_tick_applied: got x=%0d want %0d", ball_x, x0 - SPEED);
        end
    endtask

    task automatic test_wall();
        int y0;
        // bottom half moving down: wall flips upward
        y0 = m_y;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_y !== 10'(y0 - SPEED) || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL wall_flip: got y=%0d want %0d", ball_y, y0 - SPEED);
        end
        // bottom half moving up: wall ignored
        y0 = m_y;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_y !== 10'(y0 - SPEED) || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL wall_ignored: got y=%0d want %0d", ball_y, y0 - SPEED);
        end
    endtask

    task automatic test_goal_left();
        for (int i = 0; i < 400 && m_state == ST_PLAY; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            n_vec++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL goal_run[%0d]: got %h want %h", i, w_dut, model_vec());
            end
        end
        n_vec++;
        if (state !== ST_POINT || score_2 !== 4'd1 || score_1 !== 4'd0) begin
            n_err++;
            $display("FAIL left_goal_point: got st=%0d s1=%0d s2=%0d want st=3 s1=0 s2=1", state, score_1, score_2);
        end
        cyc(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (state !== ST_SERVE || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            n_err++;
            $display("FAIL left_goal_serve: got st=%0d x=%0d y=%0d want st=1 x=316 y=236", state, ball_x, ball_y);
        end
        for (int i = 0; i <= SERVE_FRAMES; i++) cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_x !== 10'd314 || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL serve_dir_left: got x=%0d want 314", ball_x);
        end
    endtask

    task automatic test_win();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6000 && m_state != ST_OVER; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            n_vec++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL win_run[%0d]: got %h want %h", i, w_dut, model_vec());
            end
        end
        n_vec++;
        if ({state, score_1, score_2, game_over} !== {ST_OVER, 4'd9, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL game_over: got st=%0d s1=%0d s2=%0d go=%0d want st=4 s1=9 s2=0 go=1",
                     state, score_1, score_2, game_over);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 1, 1);
            n_vec++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL over_frozen[%0d]: got %h want %h", i, w_dut, model_vec());
            end
        end
        cyc(0, 0, 1, 0, 0, 0);
        n_vec++;
        if ({state, score_1, score_2, game_over} !== {ST_SERVE, 4'd0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL restart: got st=%0d s1=%0d s2=%0d go=%0d want st=1 s1=0 s2=0 go=0",
                     state, score_1, score_2, game_over);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i <= SERVE_FRAMES; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 1, 1, 1);
        n_vec++;
        if (w_dut !== {ST_IDLE, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got %h want %h", w_dut, {ST_IDLE, 10'd316, 10'd236, 4'd0, 4'd0, 1'b0});
        end
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i <= SERVE_FRAMES; i++) cyc(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (ball_x !== 10'd318 || ball_y !== 10'd238 || w_dut !== model_vec()) begin
            n_err++;
            $display("FAIL post_reset_step: got x=%0d y=%0d want x=318 y=238", ball_x, ball_y);
        end
    endtask

    task automatic test_random();
        bit t, s, h1, h2, hw, r;
        for (int i = 0; i < 3000; i++) begin
            t  = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 49) == 0);
            h1 = ($urandom_range(0, 7) == 0);
            h2 = ($urandom_range(0, 7) == 0);
            hw = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 999) == 0);
            cyc(r, t, s, h1, h2, hw);
            n_vec++;
            if (w_dut !== model_vec()) begin
                n_err++;
                $display("FAIL random[%0d]: got %h want %h", i, w_dut, model_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
        hit_paddle_1 = 1'b0; hit_paddle_2 = 1'b0; hit_wall = 1'b0;
        model_reset();
        test_reset();
        test_serve();
        test_paddle();
        test_wall();
        test_goal_left();
        test_win();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
